// File: rtl/request_arbiter.sv
// Request arbiter for eight requesters.
// Fixed-priority or round-robin selection, a registered one-hot grant, and a
// bounded hold time that forces the grant to release.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no grant; arbitrate whenever any request is present
// GRANT   | one requester owns the grant; hold_cnt counts owned cycles
// RECOVER | one-cycle gap with outputs low; arbitrate for the next grant
module request_arbiter #(
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   input  logic       rr_en,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic [2:0] last_idx, last_idx_nxt;
   logic       armed, armed_nxt;
   logic [7:0] gnt_nxt;
   logic [2:0] gnt_idx_nxt;
   logic       gnt_vld_nxt;
   logic       timeout_nxt;

   logic [2:0] fix_idx;
   logic [2:0] rr_idx;
   logic [2:0] rr_cand;
   logic [2:0] win_idx;
   logic       hold_end;
   logic       owner_req;
   logic       release_grant;

   // Candidate winners for both modes; the mode is applied only when a grant is issued.
   always_comb begin
      fix_idx = 3'd0;
      rr_idx  = 3'd0;
      rr_cand = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) fix_idx = 3'(i);
      end
      // Scan from farthest to nearest so the nearest set index above last_idx wins.
      for (int k = 8; k >= 1; k--) begin
         rr_cand = last_idx + 3'(k);
         if (req[rr_cand]) rr_idx = rr_cand;
      end
      win_idx = rr_en ? rr_idx : fix_idx;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      last_idx_nxt  = last_idx;
      armed_nxt     = armed;
      gnt_nxt       = gnt;
      gnt_idx_nxt   = gnt_idx;
      gnt_vld_nxt   = gnt_vld;
      timeout_nxt   = 1'b0;
      hold_end      = (hold_cnt == HOLD_LAST);
      owner_req     = req[gnt_idx];
      release_grant = done || !owner_req || hold_end;

      case (state)
         IDLE, RECOVER: begin
            gnt_nxt      = 8'h00;
            gnt_idx_nxt  = 3'd0;
            gnt_vld_nxt  = 1'b0;
            hold_cnt_nxt = 8'd0;
            state_nxt    = IDLE;
            if (req != 8'h00) begin
               if (armed) begin
                  // Grant is registered here, so gnt appears one cycle after req is sampled.
                  state_nxt    = GRANT;
                  gnt_nxt      = 8'h01 << win_idx;
                  gnt_idx_nxt  = win_idx;
                  gnt_vld_nxt  = 1'b1;
                  last_idx_nxt = win_idx;
               end else begin
                  // The first request seen after reset only arms the arbiter.
                  armed_nxt = 1'b1;
               end
            end
         end
         GRANT: begin
            if (release_grant) begin
               state_nxt    = RECOVER;
               gnt_nxt      = 8'h00;
               gnt_idx_nxt  = 3'd0;
               gnt_vld_nxt  = 1'b0;
               hold_cnt_nxt = 8'd0;
               // Flag timeout only when the hold limit was the sole reason to release.
               timeout_nxt  = hold_end && !done && owner_req;
            end else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            gnt_nxt     = 8'h00;
            gnt_idx_nxt = 3'd0;
            gnt_vld_nxt = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         last_idx <= 3'd7;
         armed    <= 1'b0;
         gnt      <= 8'h00;
         gnt_idx  <= 3'd0;
         gnt_vld  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         last_idx <= last_idx_nxt;
         armed    <= armed_nxt;
         gnt      <= gnt_nxt;
         gnt_idx  <= gnt_idx_nxt;
         gnt_vld  <= gnt_vld_nxt;
         timeout  <= timeout_nxt;
      end
   end

endmodule

// File: doc/request_arbiter.md
REQUEST_ARBITER -- requirements
Module: request_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, legal range 2..255: maximum cycles a grant is held without done.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 req  input  8  request lines, one per requester; req[i] level-sensitive.
REQ-005 done  input  1  release strobe from the currently granted requester, sampled only in GRANT.
REQ-006 rr_en  input  1  arbitration mode: 0 = fixed priority, 1 = round robin.
REQ-007 gnt  output  8  one-hot grant vector, registered; all-zero when no grant.
REQ-008 gnt_idx  output  3  binary index of the granted requester; 0 when gnt_vld = 0.
REQ-009 gnt_vld  output  1  high whenever gnt is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-011 The state machine SHALL have three states: IDLE, GRANT, RECOVER.
REQ-012 Arbitration SHALL be evaluated in IDLE and RECOVER only; the winner is registered, giving a 1-cycle latency from sampled req to asserted gnt.
REQ-013 IDLE -> GRANT when req != 0; otherwise remain IDLE.
REQ-014 Fixed mode: the highest set index of req SHALL win (req[7] highest, req[0] lowest).
REQ-015 Round-robin mode: the winner SHALL be the lowest set index strictly above last_idx, wrapping 7 -> 0; last_idx is updated to the winner on every grant in either mode.
REQ-016 A change of rr_en SHALL take effect at the next arbitration only; it never alters an active grant.
REQ-017 In GRANT, hold_cnt (8-bit) SHALL increment every cycle from 0, starting in the first grant cycle.
REQ-018 GRANT -> RECOVER on any of: done = 1; req[gnt_idx] = 0; hold_cnt = HOLD_MAX-1.
REQ-019 The timeout pulse SHALL assert in the first RECOVER cycle only when the exit was caused by hold_cnt alone; done or a dropped req in the same cycle suppresses it.
REQ-020 In RECOVER, gnt, gnt_idx and gnt_vld SHALL be 0 for exactly one cycle; the FSM then goes to GRANT if req != 0, else IDLE.
REQ-021 Minimum gap between consecutive grants SHALL therefore be exactly one cycle, including re-grant to the same requester.
REQ-022 done asserted in IDLE or RECOVER SHALL be ignored.
REQ-023 Requests other than the granted one SHALL NOT affect an active grant; there is no preemption.
REQ-024 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-025 While rst = 0: state = IDLE, gnt = 0, gnt_idx = 0, gnt_vld = 0, timeout = 0, hold_cnt = 0, last_idx = 7, all applied asynchronously.
REQ-026 Reset asserted mid-grant SHALL drop gnt in the same cycle; after release, the first round-robin winner is the lowest set index (search starts at 0).
REQ-027 After rst deasserts, the first grant SHALL appear no earlier than the second rising edge with req != 0 sampled.

Verification
REQ-028 rr_en = 0, req = 8'b1001_0010 held, done at 3rd grant cycle -> gnt = 8'h80, gnt_idx = 7 for 3 cycles, 1 zero cycle, then gnt = 8'h80 again.
REQ-029 rr_en = 1, req = 8'hFF, done on 2nd cycle of each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, each grant 2 cycles separated by a single zero cycle.
REQ-030 HOLD_MAX = 16, req = 8'h04 held, done = 0 -> gnt = 8'h04 for exactly 16 cycles, timeout = 1 for one cycle with gnt = 0, then gnt = 8'h04 re-asserted.
REQ-031 Grant to idx 5, then req[5] dropped with req[1] = 1 -> gnt = 0 next cycle, timeout = 0, then gnt = 8'h02.
REQ-032 rst pulled low during grant to idx 3 -> all outputs 0 immediately; after release with req = 8'h88 and rr_en = 1 -> gnt_idx = 3 first.
REQ-033 done and hold_cnt = HOLD_MAX-1 in the same cycle -> release with timeout = 0; done pulsed in IDLE -> no state change.
